bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 4: number of bus registers controlled, 2..16.
REQ-002 Parameter NUM_REQ, default 2: number of transfer requesters, 1..8.
REQ-003 Localparam IW = max(1, clog2(NUM_REGS)): register index width.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester transfer request; held high until matching ack.
REQ-007 req_src  in  NUM_REQ*IW  source index; requester i occupies bits [i*IW +: IW].
REQ-008 req_dst  in  NUM_REQ*IW  destination index, same packing.
REQ-009 ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 err  out  1  valid with ack; 1 = transfer rejected, bus untouched.
REQ-011 reg_en  out  NUM_REGS  per-register bus output enable; at most one bit high.
REQ-012 reg_latch  out  NUM_REGS  per-register load strobe; at most one bit high.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 grant_id  out  clog2(NUM_REQ) (min 1)  index of current or last granted requester.

Function
REQ-015 FSM states: IDLE, DRIVE, LATCH, ACK; state register plus grant register, rr pointer, and captured src/dst.
REQ-016 All outputs decode from registered state only (Moore); no combinational path from req/req_src/req_dst to any output.
REQ-017 IDLE, no req bit high: remain in IDLE; all outputs 0 except grant_id, which holds.
REQ-018 IDLE, any req bit high: grant the first high requester searching upward from rr pointer with wrap; capture its src/dst; set rr pointer = (grant+1) mod NUM_REQ.
REQ-019 Valid grant (src != dst, both < NUM_REGS): next state DRIVE.
REQ-020 Invalid grant (src == dst or any index >= NUM_REGS): next state ACK with err flagged; reg_en/reg_latch never asserted for that transfer.
REQ-021 DRIVE: reg_en[src]=1, reg_latch=0; next state LATCH.
REQ-022 LATCH: reg_en[src]=1, reg_latch[dst]=1; the destination captures the bus on the edge ending this cycle; next state ACK.
REQ-023 ACK: ack[grant]=1 for exactly one cycle, err per REQ-020 (else 0), reg_en=reg_latch=0; next state IDLE.
REQ-024 Latency, req high in IDLE at cycle t: valid transfer -> reg_en at t+1, latch at t+2, ack at t+3, next arbitration at t+4; invalid -> ack+err at t+1, next arbitration at t+2.
REQ-025 req_src/req_dst changes after grant have no effect on the in-flight transfer.
REQ-026 req bits change only in IDLE arbitration; deassertion of a granted req mid-transfer does not abort it.
REQ-027 A requester still holding req in the IDLE cycle after its ack is treated as a new request (back-to-back allowed); rr pointer gives other pending requesters priority first.
REQ-028 NUM_REQ=1: rr pointer stays 0; grant_id constant 0.
REQ-029 ack, reg_en, reg_latch are each zero or one-hot in every cycle.

Reset
REQ-030 reset high at a posedge: state=IDLE, rr pointer=0, grant_id=0, captured src/dst=0; ack, err, reg_en, reg_latch, busy all 0 from the following cycle.
REQ-031 Reset in DRIVE, LATCH or ACK aborts the transfer: no ack issued; no reg_latch after the reset edge.
REQ-032 Reset dominates req; arbitration resumes on the first cycle with reset low.

Verification
REQ-033 Single transfer: req[0]=1, src0=1, dst0=3 at t -> reg_en=0010 at t+1; reg_en=0010, reg_latch=1000 at t+2; ack=01, err=0 at t+3; busy low at t+4.
REQ-034 Reject: req[1]=1, src1=dst1=2 -> ack=10, err=1 at t+1; reg_en/reg_latch zero throughout.
REQ-035 Fairness: req=11 held continuously after reset -> grants alternate 0,1,0,1; ack pulses every 4 cycles; neither requester starves.
REQ-036 Reset mid-transfer: reset high in LATCH cycle -> next cycle all outputs 0, no ack; then req[0] with src=0, dst=1 completes normally with ack at t+3.
REQ-037 Operand stability: change req_src0 from 1 to 2 in DRIVE -> reg_en stays 0010 through LATCH.
REQ-038 Bench checks every cycle: one-hot-or-zero on ack, reg_en, reg_latch; busy==(state!=IDLE).

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl
//   Arbitrates transfer requests between NUM_REQ requesters and sequences
//   register-to-register moves over a shared bus: the source register drives
//   the bus (DRIVE), the destination captures it (LATCH), and the requester
//   is acknowledged (ACK). Requests whose source equals the destination, or
//   that name a register outside the file, are acknowledged with err set and
//   never touch the bus. Round-robin arbitration; all outputs are decoded
//   from registered state only.
//
// Ports
//   clk        clock, all state changes on posedge
//   reset      synchronous active-high reset
//   req        per-requester request, held until ack
//   req_src    packed source indices, requester i at [i*IW +: IW]
//   req_dst    packed destination indices, same packing
//   ack        one-cycle completion pulse to the granted requester
//   err        valid with ack: transfer rejected
//   reg_en     per-register bus output enable (zero or one-hot)
//   reg_latch  per-register load strobe (zero or one-hot)
//   busy       high whenever not idle
//   grant_id   current or last granted requester
module bus_xfer_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int NUM_REQ  = 2,
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int GW = (NUM_REQ  > 1) ? $clog2(NUM_REQ)  : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*IW-1:0] req_src,
  input  logic [NUM_REQ*IW-1:0] req_dst,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  err,
  output logic [NUM_REGS-1:0]   reg_en,
  output logic [NUM_REGS-1:0]   reg_latch,
  output logic                  busy,
  output logic [GW-1:0]         grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_LATCH = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, w_grant_nxt;
  logic [GW-1:0]   r_rr,    w_rr_nxt;
  logic [IW-1:0]   r_src,   w_src_nxt;
  logic [IW-1:0]   r_dst,   w_dst_nxt;
  logic            r_err,   w_err_nxt;

  // Round-robin search split in two halves: requesters at or above the
  // pointer win over those below it, lowest index first within each half.
  logic            w_hi_found, w_lo_found, w_found;
  logic [GW-1:0]   w_hi_idx, w_lo_idx, w_sel_idx;
  logic [IW-1:0]   w_hi_src, w_hi_dst, w_lo_src, w_lo_dst;
  logic [IW-1:0]   w_sel_src, w_sel_dst;
  logic            w_valid;

  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_src   = '0;
    w_hi_dst   = '0;
    w_lo_src   = '0;
    w_lo_dst   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        if (i >= 32'(r_rr)) begin
          if (!w_hi_found) begin
            w_hi_found = 1'b1;
            w_hi_idx   = GW'(i);
            w_hi_src   = req_src[i*IW +: IW];
            w_hi_dst   = req_dst[i*IW +: IW];
          end
        end else if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = GW'(i);
          w_lo_src   = req_src[i*IW +: IW];
          w_lo_dst   = req_dst[i*IW +: IW];
        end
      end
    end
    w_found   = w_hi_found | w_lo_found;
    w_sel_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    w_sel_src = w_hi_found ? w_hi_src : w_lo_src;
    w_sel_dst = w_hi_found ? w_hi_dst : w_lo_dst;
    w_valid   = (w_sel_src != w_sel_dst)
             && (32'(w_sel_src) < 32'(NUM_REGS))
             && (32'(w_sel_dst) < 32'(NUM_REGS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_rr    <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_rr    <= w_rr_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_err_nxt   = r_err;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_sel_idx;
          w_src_nxt   = w_sel_src;
          w_dst_nxt   = w_sel_dst;
          w_err_nxt   = !w_valid;
          w_rr_nxt    = (32'(w_sel_idx) == 32'(NUM_REQ - 1)) ? '0 : w_sel_idx + 1'b1;
          w_state_nxt = w_valid ? S_DRIVE : S_ACK;
        end
      end
      S_DRIVE: w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Moore outputs from registered state. r_src/r_dst are only decoded in
    // DRIVE/LATCH, which are reached solely for in-range indices.
    reg_en    = '0;
    reg_latch = '0;
    ack       = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_en[i]    = ((r_state == S_DRIVE) || (r_state == S_LATCH)) && (32'(r_src) == i);
      reg_latch[i] = (r_state == S_LATCH) && (32'(r_dst) == i);
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ack[i] = (r_state == S_ACK) && (32'(r_grant) == i);
    end
    err      = (r_state == S_ACK) && r_err;
    busy     = (r_state != S_IDLE);
    grant_id = r_grant;
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model turns each arbitration into a queue of expected output
//   cycles; every cycle the DUT outputs are compared against it.
module tb_bus_xfer_ctrl;
  localparam int NUM_REGS = 4;
  localparam int NUM_REQ  = 2;
  localparam int IW = 2;
  localparam int GW = 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*IW-1:0] req_src = '0;
  logic [NUM_REQ*IW-1:0] req_dst = '0;
  logic [NUM_REQ-1:0]    ack;
  logic                  err;
  logic [NUM_REGS-1:0]   reg_en;
  logic [NUM_REGS-1:0]   reg_latch;
  logic                  busy;
  logic [GW-1:0]         grant_id;

  bus_xfer_ctrl #(.NUM_REGS(NUM_REGS), .NUM_REQ(NUM_REQ)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_src(req_src), .req_dst(req_dst),
    .ack(ack), .err(err), .reg_en(reg_en), .reg_latch(reg_latch),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REGS-1:0] en;
    logic [NUM_REGS-1:0] latch;
    logic [NUM_REQ-1:0]  ack;
    logic                err;
    logic                busy;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   rr;
  int   gid;
  int   n_checks;
  int   n_pass;
  int   cyc;

  function automatic exp_t idle_rec();
    exp_t r;
    r.en = '0; r.latch = '0; r.ack = '0; r.err = 1'b0; r.busy = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  // Reference model: one step per clock edge, using the inputs sampled there.
  task automatic model_step();
    exp_t r;
    int   g;
    logic [IW-1:0] s, d;
    if (reset) begin
      q.delete();
      cur = idle_rec();
      rr  = 0;
      gid = 0;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (cur.busy) begin
      cur = idle_rec();
    end else if (req != '0) begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && req[(rr + k) % NUM_REQ]) g = (rr + k) % NUM_REQ;
      s   = req_src[g*IW +: IW];
      d   = req_dst[g*IW +: IW];
      gid = g;
      rr  = (g + 1) % NUM_REQ;
      if (s != d && int'(s) < NUM_REGS && int'(d) < NUM_REGS) begin
        r = idle_rec(); r.busy = 1'b1; r.en[s] = 1'b1;
        q.push_back(r);
        r.latch[d] = 1'b1;
        q.push_back(r);
        r = idle_rec(); r.busy = 1'b1; r.ack[g] = 1'b1;
        q.push_back(r);
      end else begin
        r = idle_rec(); r.busy = 1'b1; r.ack[g] = 1'b1; r.err = 1'b1;
        q.push_back(r);
      end
      cur = q.pop_front();
    end else begin
      cur = idle_rec();
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("ack",       32'(ack),       32'(cur.ack));
    chk("err",       32'(err),       32'(cur.err));
    chk("reg_en",    32'(reg_en),    32'(cur.en));
    chk("reg_latch", 32'(reg_latch), 32'(cur.latch));
    chk("busy",      32'(busy),      32'(cur.busy));
    chk("grant_id",  32'(grant_id),  32'(gid));
    chk("oh_ack",    32'($onehot0(ack)),       32'd1);
    chk("oh_en",     32'($onehot0(reg_en)),    32'd1);
    chk("oh_latch",  32'($onehot0(reg_latch)), 32'd1);
  endtask

  task automatic set_op(input int i, input int s, input int d);
    req_src[i*IW +: IW] = IW'(s);
    req_dst[i*IW +: IW] = IW'(d);
  endtask

  task automatic rand_op(input int i);
    int s, d;
    s = int'($urandom_range(NUM_REGS - 1));
    d = ($urandom_range(4) == 0) ? s : int'($urandom_range(NUM_REGS - 1));
    set_op(i, s, d);
  endtask

  int nack, last_ack;

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    cur = idle_rec(); rr = 0; gid = 0;

    // reset and idle
    reset = 1'b1;
    cycle(); cycle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid",  32'(grant_id), 32'd0);
    reset = 1'b0;
    cycle(); cycle();

    // single valid transfer: src0=1 -> dst0=3
    req = 2'b01; set_op(0, 1, 3);
    cycle(); chk("single_en_t1", 32'(reg_en), 32'b0010);
             chk("single_lat_t1", 32'(reg_latch), 32'b0000);
    cycle(); chk("single_en_t2", 32'(reg_en), 32'b0010);
             chk("single_lat_t2", 32'(reg_latch), 32'b1000);
    cycle(); chk("single_ack_t3", 32'(ack), 32'b01);
             chk("single_err_t3", 32'(err), 32'd0);
    req = 2'b00;
    cycle(); chk("single_busy_t4", 32'(busy), 32'd0);

    // rejected transfer: src1 == dst1
    req = 2'b10; set_op(1, 2, 2);
    cycle(); chk("rej_ack", 32'(ack), 32'b10);
             chk("rej_err", 32'(err), 32'd1);
             chk("rej_en",  32'(reg_en), 32'd0);
             chk("rej_gid", 32'(grant_id), 32'd1);
    req = 2'b00;
    cycle(); chk("rej_busy", 32'(busy), 32'd0);

    // operand change after grant has no effect
    req = 2'b01; set_op(0, 1, 3);
    cycle(); chk("stab_en_drive", 32'(reg_en), 32'b0010);
    set_op(0, 2, 0);
    cycle(); chk("stab_en_latch", 32'(reg_en), 32'b0010);
             chk("stab_lat", 32'(reg_latch), 32'b1000);
    cycle(); chk("stab_ack", 32'(ack), 32'b01);
    req = 2'b00;
    cycle();

    // reset during LATCH aborts, then a fresh transfer completes
    req = 2'b01; set_op(0, 1, 2);
    cycle(); cycle();
    chk("abort_in_latch", 32'(reg_latch), 32'b0100);
    reset = 1'b1;
    cycle(); chk("abort_ack", 32'(ack), 32'd0);
             chk("abort_lat", 32'(reg_latch), 32'd0);
             chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0; set_op(0, 0, 1);
    cycle(); chk("resume_en", 32'(reg_en), 32'b0001);
    cycle(); chk("resume_lat", 32'(reg_latch), 32'b0010);
    cycle(); chk("resume_ack", 32'(ack), 32'b01);
    req = 2'b00;
    cycle();

    // fairness: both requesters held continuously after reset
    reset = 1'b1; cycle(); reset = 1'b0;
    req = 2'b11; set_op(0, 0, 1); set_op(1, 2, 3);
    nack = 0; last_ack = 0;
    for (int j = 1; j <= 20; j++) begin
      cycle();
      if (ack != '0) begin
        chk("fair_gid", 32'(grant_id), 32'(nack % 2));
        if (nack > 0) chk("fair_gap", 32'(j - last_ack), 32'd4);
        last_ack = j;
        nack++;
      end
    end
    chk("fair_count", 32'(nack), 32'd5);
    req = 2'b00;
    cycle(); cycle();

    // randomized traffic with occasional reset and operand churn
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(99) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cur.ack[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
          else rand_op(i);
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            req[i] = 1'b1;
            rand_op(i);
          end
        end else if ($urandom_range(9) == 0) begin
          rand_op(i);
        end else if ($urandom_range(29) == 0) begin
          req[i] = 1'b0;
        end
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
